// File: rtl/sevga_pkg.sv
// Shared types and defaults for the VRAM write path: frame-buffer geometry,
// write-FSM state enum and the buffered CPU write entry.
package sevga_pkg;

  localparam logic [23:0] FbBaseDefault  = 24'h3FA700;
  localparam int unsigned FbBytesDefault = 21888;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe
  } wrState_e;

  typedef struct packed {
    logic [14:0] offset;
    logic [15:0] data;
    logic        ube;
    logic        lbe;
  } wrEntry_t;

endpackage

// File: rtl/wrfifo.sv
// Synchronous show-ahead FIFO for buffered CPU write entries.
// Depth must be a power of two, at least 2.
module wrfifo
  import sevga_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     pixClock,
  input  logic     reset,
  input  logic     wrEn,
  input  wrEntry_t wrData,
  input  logic     rdEn,
  output wrEntry_t rdData,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  wrEntry_t        mem [Depth];
  logic [PtrW:0]   wrPtr;
  logic [PtrW:0]   rdPtr;
  logic            doWr;
  logic            doRd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[PtrW] != rdPtr[PtrW]) && (wrPtr[PtrW-1:0] == rdPtr[PtrW-1:0]);
  assign doWr   = wrEn && !full;
  assign doRd   = rdEn && !empty;
  assign rdData = mem[rdPtr[PtrW-1:0]];

  always_ff @(posedge pixClock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + (PtrW+1)'(1);
      if (doRd) rdPtr <= rdPtr + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge pixClock) begin
    if (doWr) mem[wrPtr[PtrW-1:0]] <= wrData;
  end

endmodule

// File: rtl/vram_writer.sv
// Captures 68000 writes into the frame buffer and replays them as byte writes
// to VRAM outside the display read slot. Optional sticky overflow flag: VRAM_WRITER_OVF_EN.
module vram_writer
  import sevga_pkg::*;
#(
  parameter logic [23:0] FB_BASE    = FbBaseDefault,
  parameter int unsigned FB_BYTES   = FbBytesDefault,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        pixClock,
  input  logic        reset,
  input  logic [9:0]  hCount,
  input  logic [22:0] cpuAddr,
  input  logic [15:0] cpuData,
  input  logic        nAS,
  input  logic        nUDS,
  input  logic        nLDS,
  input  logic        cpuRnW,
  output logic [14:0] vramAddr,
  output logic [7:0]  vramDataOut,
  output logic        vramDataOE,
  output logic        nvramWE,
  output logic        vramBusReq,
  output logic        fifoOverflow
);

  localparam logic [24:0] FbEnd = 25'(FB_BASE) + 25'(FB_BYTES);

  logic [1:0] asSync, udsSync, ldsSync, rnwSync;
  logic       prevBothQ;
  logic       bothLow, capture, inRange, accept;
  logic [23:0] byteAddr, offDiff;
  wrEntry_t   pushEntry, head;
  logic       fifoFull, fifoEmpty, pop;
  wrState_e   stateQ, stateD;
  logic       upperDoneQ, upperDoneD;
  logic       slotOk, curUpper;
  logic [14:0] curAddr;
  logic [7:0]  curData;

  always_ff @(posedge pixClock) begin
    if (reset) begin
      asSync    <= 2'b11;
      udsSync   <= 2'b11;
      ldsSync   <= 2'b11;
      rnwSync   <= 2'b11;
      prevBothQ <= 1'b1;
    end else begin
      asSync    <= {asSync[0], nAS};
      udsSync   <= {udsSync[0], nUDS};
      ldsSync   <= {ldsSync[0], nLDS};
      rnwSync   <= {rnwSync[0], cpuRnW};
      prevBothQ <= udsSync[1] & ldsSync[1];
    end
  end

  assign bothLow  = ~(udsSync[1] & ldsSync[1]);
  assign capture  = prevBothQ && bothLow && !asSync[1] && !rnwSync[1];
  assign byteAddr = {cpuAddr, 1'b0};
  assign offDiff  = byteAddr - FB_BASE;
  assign inRange  = (byteAddr >= FB_BASE) && ({1'b0, byteAddr} < FbEnd);
  assign accept   = capture && inRange;

  assign pushEntry = '{offset: offDiff[14:0], data: cpuData,
                       ube: ~udsSync[1], lbe: ~ldsSync[1]};

  wrfifo #(
    .Depth (FIFO_DEPTH)
  ) u_wrfifo (
    .pixClock (pixClock),
    .reset    (reset),
    .wrEn     (accept),
    .wrData   (pushEntry),
    .rdEn     (pop),
    .rdData   (head),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // hCount[2:0] = 5..7 belongs to the display read slot.
  assign slotOk   = (hCount[2:0] <= 3'd4);
  assign curUpper = head.ube && !upperDoneQ;
  assign curAddr  = curUpper ? head.offset : head.offset + 15'd1;
  assign curData  = curUpper ? head.data[15:8] : head.data[7:0];

  always_ff @(posedge pixClock) begin
    if (reset) begin
      stateQ     <= StIdle;
      upperDoneQ <= 1'b0;
    end else begin
      stateQ     <= stateD;
      upperDoneQ <= upperDoneD;
    end
  end

  always_comb begin
    stateD      = stateQ;
    upperDoneD  = upperDoneQ;
    pop         = 1'b0;
    vramAddr    = '0;
    vramDataOut = '0;
    vramDataOE  = 1'b0;
    vramBusReq  = 1'b0;
    nvramWE     = 1'b1;
    unique case (stateQ)
      StIdle: begin
        if (!fifoEmpty && slotOk) stateD = StSetup;
      end
      StSetup: begin
        vramBusReq  = 1'b1;
        vramDataOE  = 1'b1;
        vramAddr    = curAddr;
        vramDataOut = curData;
        stateD      = StStrobe;
      end
      StStrobe: begin
        vramBusReq  = 1'b1;
        vramDataOE  = 1'b1;
        vramAddr    = curAddr;
        vramDataOut = curData;
        nvramWE     = 1'b0;
        if (curUpper && head.lbe) begin
          upperDoneD = 1'b1;
          stateD     = slotOk ? StSetup : StIdle;
        end else begin
          pop        = 1'b1;
          upperDoneD = 1'b0;
          stateD     = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

`ifdef VRAM_WRITER_OVF_EN
  logic ovfQ;
  always_ff @(posedge pixClock) begin
    if (reset) ovfQ <= 1'b0;
    else if (accept && fifoFull) ovfQ <= 1'b1;
  end
  assign fifoOverflow = ovfQ;
`else
  logic unusedFull;
  assign unusedFull   = fifoFull;
  assign fifoOverflow = 1'b0;
`endif

  logic unusedBits;
  assign unusedBits = ^{hCount[9:3], offDiff[23:15]};

endmodule

// File: tb/tb_vram_writer.sv
// Scoreboard bench for vram_writer: stimulus pushes expected VRAM byte writes,
// a monitor pops and compares on every falling nvramWE.
module tb_vram_writer;

  logic        pixClock = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  hCount = '0;
  logic [22:0] cpuAddr = '0;
  logic [15:0] cpuData = '0;
  logic        nAS = 1'b1, nUDS = 1'b1, nLDS = 1'b1, cpuRnW = 1'b1;
  logic [14:0] vramAddr;
  logic [7:0]  vramDataOut;
  logic        vramDataOE, nvramWE, vramBusReq, fifoOverflow;

  int checks = 0;
  int errors = 0;
  logic [22:0] expQ[$];
  bit          hRun = 1'b0;
  logic [9:0]  hHold = '0;

  vram_writer dut (
    .pixClock     (pixClock),
    .reset        (reset),
    .hCount       (hCount),
    .cpuAddr      (cpuAddr),
    .cpuData      (cpuData),
    .nAS          (nAS),
    .nUDS         (nUDS),
    .nLDS         (nLDS),
    .cpuRnW       (cpuRnW),
    .vramAddr     (vramAddr),
    .vramDataOut  (vramDataOut),
    .vramDataOE   (vramDataOE),
    .nvramWE      (nvramWE),
    .vramBusReq   (vramBusReq),
    .fifoOverflow (fifoOverflow)
  );

  always #5 pixClock = ~pixClock;

  // Timing generator stand-in: free-running or held at hHold.
  initial forever begin
    @(posedge pixClock);
    #2;
    if (hRun) hCount = hCount + 10'd1;
    else      hCount = hHold;
  end

  // Monitor: one check of address/data/bus per strobe, one of the slot it used.
  logic       weLast = 1'b1;
  logic [2:0] hPrev = '0;
  logic [22:0] expW;
  always @(negedge pixClock) begin
    if (!nvramWE && weLast) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", vramAddr, vramDataOut);
      end else begin
        expW = expQ.pop_front();
        if ({vramAddr, vramDataOut} !== expW || vramBusReq !== 1'b1 || vramDataOE !== 1'b1) begin
          errors++;
          $display("FAIL vram_write actual addr=%h data=%h req=%b oe=%b expected addr=%h data=%h",
                   vramAddr, vramDataOut, vramBusReq, vramDataOE, expW[22:8], expW[7:0]);
        end
      end
      checks++;
      if (hPrev > 3'd4) begin
        errors++;
        $display("FAIL setup_slot actual hCount[2:0]=%0d expected 0..4", hPrev);
      end
    end
    weLast = nvramWE;
    hPrev  = hCount[2:0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expectWr(input logic [14:0] a, input logic [7:0] d);
    expQ.push_back({a, d});
  endtask

  task automatic cpuSetup(input logic [23:0] a, input logic [15:0] d);
    cpuAddr = a[23:1];
    cpuData = d;
    nAS     = 1'b0;
    cpuRnW  = 1'b0;
  endtask

  task automatic cpuRelease();
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; cpuRnW = 1'b1;
  endtask

  task automatic cpuWrite(input logic [23:0] a, input logic [15:0] d, input bit u, input bit l);
    @(posedge pixClock); #1;
    cpuSetup(a, d);
    @(posedge pixClock); #1;
    nUDS = ~u;
    nLDS = ~l;
    repeat (4) @(posedge pixClock);
    #1 cpuRelease();
    repeat (3) @(posedge pixClock);
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(posedge pixClock);
      n++;
    end
    repeat (4) @(posedge pixClock);
    chk(name, expQ.size(), 0);
    expQ.delete();
  endtask

  bit seen;
  logic expOvf;

  initial begin
`ifdef VRAM_WRITER_OVF_EN
    expOvf = 1'b1;
`else
    expOvf = 1'b0;
`endif
    // Reset state
    repeat (3) @(posedge pixClock);
    #1;
    chk("rst_nvramWE", nvramWE, 1);
    chk("rst_busReq", vramBusReq, 0);
    chk("rst_dataOE", vramDataOE, 0);
    chk("rst_addr", vramAddr, 0);
    chk("rst_data", vramDataOut, 0);
    chk("rst_ovf", fifoOverflow, 0);
    reset = 1'b0;

    // Word write, big-endian byte order, free-running hCount
    hRun = 1'b1;
    expectWr(15'h0000, 8'hA5);
    expectWr(15'h0001, 8'h5A);
    cpuWrite(24'h3FA700, 16'hA55A, 1, 1);
    waitDrain("drain_word", 200);

    // LDS-only write
    expectWr(15'h0003, 8'hC3);
    cpuWrite(24'h3FA702, 16'h00C3, 0, 1);
    waitDrain("drain_lds", 200);

    // Out-of-range on both sides, then the last in-range word
    cpuWrite(24'h3FA6FE, 16'hDEAD, 1, 1);
    cpuWrite(24'h3FFC80, 16'hBEEF, 1, 1);
    repeat (40) @(posedge pixClock);
    expectWr(15'h557E, 8'h11);
    expectWr(15'h557F, 8'h22);
    cpuWrite(24'h3FFC7E, 16'h1122, 1, 1);
    waitDrain("drain_last_word", 200);

    // Five writes during the display slot: four buffered, fifth dropped
    hHold = 10'd6;
    hRun  = 1'b0;
    repeat (2) @(posedge pixClock);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expectWr(15'h0010 + 15'(2 * i), 8'h40 + 8'(i));
      cpuWrite(24'h3FA710 + 24'(2 * i), {8'h40 + 8'(i), 8'h00}, 1, 0);
    end
    repeat (20) @(posedge pixClock);
    #1 chk("ovf_flag", fifoOverflow, expOvf);
    chk("held_pending", expQ.size(), 4);
    hRun = 1'b1;
    waitDrain("drain_four", 300);
    repeat (40) @(posedge pixClock);

    // Reset during STROBE drops the in-flight entry
    hRun  = 1'b0;
    hHold = 10'd6;
    expectWr(15'h0020, 8'h12);
    cpuWrite(24'h3FA720, 16'h1234, 1, 1);
    hRun = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge pixClock);
      if (!nvramWE) seen = 1'b1;
    end
    chk("strobe_seen", seen, 1);
    reset = 1'b1;
    @(posedge pixClock); #1;
    chk("rststrobe_nvramWE", nvramWE, 1);
    chk("rststrobe_busReq", vramBusReq, 0);
    chk("rststrobe_ovf", fifoOverflow, 0);
    reset = 1'b0;
    repeat (60) @(posedge pixClock);
    chk("rststrobe_fifo_empty", expQ.size(), 0);

    // Push coinciding with the final pop at count 1
    hRun  = 1'b0;
    hHold = 10'd6;
    repeat (2) @(posedge pixClock);
    expectWr(15'h0030, 8'h77);
    cpuWrite(24'h3FA730, 16'h7700, 1, 0);
    @(posedge pixClock); #1;
    cpuSetup(24'h3FA732, 16'h0088);
    repeat (2) @(posedge pixClock);
    @(posedge pixClock); #1;
    expectWr(15'h0033, 8'h88);
    hHold = 10'd0;
    nLDS  = 1'b0;
    repeat (5) @(posedge pixClock);
    #1 cpuRelease();
    waitDrain("drain_push_pop", 200);

    chk("final_queue_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
